// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB-first by default, with a valid/ack byte handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  start_edge, byte_done, parity_ok;
`ifdef UART_RX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // History flop makes a held-low line (break) unable to re-trigger.
  assign start_edge = prev_q & ~sync2_q;

`ifdef UART_RX_PARITY_EN
  assign parity_ok = ~(^shift_q ^ parity_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    byte_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d     = parity_q;
`endif

    if (rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d    = '0;
          parity_d = sync2_q;
          state_d  = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          cnt_d        = '0;
          state_d      = StIdle;
          frame_err_d  = ~sync2_q;
          parity_err_d = ~parity_ok;
          byte_done    = sync2_q & parity_ok;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A same-cycle ack consumes the old byte, so no overrun is flagged.
    if (byte_done) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = rx_ack ? 1'b0 : (overrun_q | valid_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      sync1_q      <= uart_rxd;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_busy       = (state_q != StIdle);
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;
  assign rx_parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed/randomised bench for uart_rx; frames are built bit-by-bit from the wire format and
// expected outputs come from a frame-level model of the handshake rules.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Db  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBits = Db + 3;
`else
  localparam int NBits = Db + 2;
`endif
  // Edge index (counted from the edge after which the start bit is driven) that registers the
  // stop decision: 2 sync cycles + 1 edge-detect cycle + half bit + (NBits-1) bit periods.
  localparam int Done = Cpb / 2 + (NBits - 1) * Cpb + 3;

  logic          clk, reset_n, uart_rxd, rx_ack;
  logic [Db-1:0] rx_data;
  logic          rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err;

  uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (Db)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_rxd     (uart_rxd),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_parity_err(rx_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [Db-1:0] exp_data;
  logic          exp_valid, exp_overrun;

  int valid_at, busy_fall_at, fe_cnt, fe_at, pe_cnt, pe_at, busy_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"}, 32'(rx_data), 32'(exp_data));
    chk({tag, ".valid"}, 32'(rx_valid), 32'(exp_valid));
    chk({tag, ".overrun"}, 32'(rx_overrun), 32'(exp_overrun));
    chk({tag, ".busy"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data"}, 32'(rx_data), 32'd0);
    chk({tag, ".flags"}, {26'd0, rx_valid, rx_busy, rx_frame_err, rx_overrun, rx_parity_err},
        32'd0);
  endtask

  // Drives one frame; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [Db-1:0] d, input logic par, input logic stop,
                            input bit ack_done);
    logic [NBits-1:0] frame;
    logic             v_prev, busy_seen, good;
    frame = '0;
    frame[Db:1] = d;
`ifdef UART_RX_PARITY_EN
    frame[Db+1] = par;
`endif
    frame[NBits-1] = stop;
    valid_at = -1; busy_fall_at = -1; fe_cnt = 0; fe_at = -1; pe_cnt = 0; pe_at = -1;
    v_prev = rx_valid;
    busy_seen = 1'b0;
    for (int i = 0; i < NBits * int'(Cpb); i++) begin
      uart_rxd = frame[i / Cpb];
      rx_ack   = ack_done && (i == Done - 1);
      tick();
      if (rx_frame_err) begin fe_cnt++; fe_at = i + 1; end
      if (rx_parity_err) begin pe_cnt++; pe_at = i + 1; end
      if (rx_busy) busy_seen = 1'b1;
      if (busy_seen && !rx_busy && busy_fall_at < 0) busy_fall_at = i + 1;
      if (rx_valid && !v_prev && valid_at < 0) valid_at = i + 1;
      v_prev = rx_valid;
    end
    rx_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
    good = stop && ((^d ^ par) == 1'b0);
`else
    good = stop;
`endif
    if (good) begin
      exp_overrun = ack_done ? 1'b0 : (exp_overrun | exp_valid);
      exp_valid   = 1'b1;
      exp_data    = d;
    end else if (ack_done && exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    logic [Db-1:0] b;
    logic          ackr;
    reset_n = 1'b0; uart_rxd = 1'b1; rx_ack = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_overrun = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset_held");
    reset_n = 1'b1;
    repeat (4) tick();
    chk_all_zero("reset_released");

    // 0xA5 with exact output timing
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("a5.valid_at", 32'(valid_at), 32'(Done));
    chk("a5.busy_fall_at", 32'(busy_fall_at), 32'(Done));
    chk("a5.fe_cnt", 32'(fe_cnt), 32'd0);
    idle(8);
    chk_model("a5");

    // Ack clears; ack while empty is ignored
    ack_pulse();
    chk_model("ack1");
    ack_pulse();
    chk_model("ack_idle");

    // Overrun: two bytes without ack
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    idle(4);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk_model("overrun");
    ack_pulse();
    chk_model("overrun_ack");

    // Random pair, second completes in the same cycle as an ack
    b = 8'($urandom);
    send_frame(b, 1'b0, 1'b1, 1'b0);
    idle(4);
    b = 8'($urandom);
    send_frame(b, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk_model("ack_same_cycle");
    ack_pulse();

    // 4-cycle low glitch on an idle line
    busy_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      uart_rxd = (i < 4) ? 1'b0 : 1'b1;
      tick();
      if (rx_busy) busy_cnt++;
      if (rx_frame_err) fe_cnt++;
    end
    chk("glitch.busy_cycles", 32'(busy_cnt), 32'(Cpb / 2));
    chk("glitch.fe_cnt", 32'(fe_cnt), 32'd0);
    chk_model("glitch");

    // Framing error keeps the previous byte; held-low line must not restart a frame
    b = 8'($urandom);
    send_frame(b, 1'b0, 1'b1, 1'b0);
    idle(4);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk("ferr.fe_cnt", 32'(fe_cnt), 32'd1);
    chk("ferr.fe_at", 32'(fe_at), 32'(Done));
    busy_cnt = 0;
    repeat (3 * Cpb) begin
      tick();
      if (rx_busy) busy_cnt++;
    end
    chk("break.busy_cycles", 32'(busy_cnt), 32'd0);
    chk_model("ferr");
    idle(Cpb);
    b = 8'($urandom);
    send_frame(b, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk_model("after_break");

    // Reset in the middle of data bit 4
    for (int i = 0; i < 5 * int'(Cpb) + int'(Cpb / 2); i++) begin
      uart_rxd = (i < int'(Cpb)) ? 1'b0 : 1'($urandom);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    exp_data = '0; exp_valid = 1'b0; exp_overrun = 1'b0;
    chk_all_zero("midframe_reset_async");
    tick();
    uart_rxd = 1'b1;
    repeat (3) tick();
    chk_all_zero("midframe_reset_held");
    reset_n = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    chk("r81.valid_at", 32'(valid_at), 32'(Done));
    idle(4);
    chk_model("r81");
    ack_pulse();

    // Random good frames with random acks
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      ackr = 1'($urandom);
      send_frame(b, ^b, 1'b1, ackr);
      chk("rand.busy_fall_at", 32'(busy_fall_at), 32'(Done));
      idle(3);
      chk_model("rand");
    end
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_ok.pe_cnt", 32'(pe_cnt), 32'd0);
    idle(4);
    chk_model("par_ok");
    ack_pulse();
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    chk("par_bad.pe_cnt", 32'(pe_cnt), 32'd1);
    chk("par_bad.pe_at", 32'(pe_at), 32'(Done));
    idle(4);
    chk_model("par_bad");
`else
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    chk("nopar.pe_cnt", 32'(pe_cnt), 32'd0);
    idle(4);
    chk_model("nopar");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart to the block's existing UART transmit path (8N1, LSB first, idle high).
- Synchronises the serial line and detects start bits. Samples each bit at its centre and presents the received byte with a valid/ack handshake.
- Sits between the chip's serial input pin and the latch/sum logic. It lets operands be loaded over the same UART link used for results.

Parameters:
- CLKS_PER_BIT, 1042, clk cycles per bit period (10 MHz / 9600 baud); must be >= 4.
- DATA_BITS, 8, data bits per frame; rx_data width.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- uart_rxd  input  1  serial line from pin, asynchronous to clk, idle high
- rx_ack  input  1  consumer acknowledge; clears rx_valid/rx_overrun
- rx_data  output  DATA_BITS  last good received byte, LSB = first bit on the wire
- rx_valid  output  1  byte available; held until acked
- rx_busy  output  1  high while a frame is in progress (state != IDLE)
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled low
- rx_overrun  output  1  sticky: a new byte completed while rx_valid was already high
- rx_parity_err  output  1  one-cycle pulse: parity mismatch (optional feature only, else 0)

Behaviour:

Reset:
- Asynchronous on reset_n low. rx_data=0, rx_valid=0, rx_busy=0, rx_frame_err=0, rx_overrun=0, rx_parity_err=0.
- Both synchroniser flops = 1, state=IDLE, counters=0.
- Reset mid-frame abandons the frame with no output change except the values above.

Input synchroniser:
- 2-FF synchroniser on uart_rxd, plus one history flop for edge detection.
- A start edge is synced=0 while the previous value was 1.

State machine:
- IDLE:
  - On start edge, clear baud counter and go to START.
  - A line held low (break) never re-triggers without first returning high.
- START:
  - Count CLKS_PER_BIT/2 cycles (integer division), then sample.
  - Sample 0: go to DATA with the bit counter cleared.
  - Sample 1: glitch; return to IDLE with no output activity.
- DATA:
  - Every CLKS_PER_BIT cycles, sample and shift into the shift register from the MSB side (LSB-first reception).
  - After DATA_BITS samples, go to STOP (or PARITY when the optional feature is enabled).
- STOP:
  - After CLKS_PER_BIT cycles, sample.
  - Sample 1: rx_data <= shift register; rx_valid <= 1.
  - Sample 0: rx_frame_err pulses for 1 cycle; rx_data and rx_valid are unchanged.
  - Either way, return to IDLE in the same cycle. This is mid-stop-bit, so the next start edge is detectable.

Timing:
- Sampling points are measured from the cycle the start edge is seen on the synchronised signal.
  - Start sample: CLKS_PER_BIT/2 cycles after the edge.
  - Data bit n (n from 0): CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT cycles after the edge.
  - Stop sample: CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the edge.
- rx_valid and rx_frame_err become visible the cycle after the stop sample.
- Pin-to-edge detection adds 2 clk of synchroniser latency.

Handshake:
- rx_ack while rx_valid=1 clears rx_valid and rx_overrun on the next edge. rx_ack while rx_valid=0 is ignored.
- New byte while rx_valid=1 and no rx_ack: rx_data is overwritten, rx_valid stays 1, and rx_overrun is set (sticky until acked).
- New byte and rx_ack in the same cycle: the ack consumes the old byte. rx_valid stays 1 with the new data and rx_overrun=0.
- rx_busy is asserted from the cycle after the start edge until the return to IDLE. It deasserts on a glitch rejection.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA, sampled CLKS_PER_BIT cycles after the last data bit. Even parity over the data bits.
  - All subsequent timing shifts by one bit period.
  - On mismatch the byte is discarded and rx_parity_err pulses 1 cycle, coincident with the stop-bit decision. rx_frame_err may pulse in the same cycle if the stop bit is also low.
- Undefined: no PARITY state; rx_parity_err is tied to 0.

Test Plan:
All tests use CLKS_PER_BIT=16.
- Reset, then send 0xA5 8N1 -> rx_data=0xA5 and rx_valid=1 the cycle after the stop sample (about 154 clk after the start edge), rx_busy low afterwards.
- 0x3C received with no ack, then 0xC3 -> rx_data=0xC3, rx_valid=1, rx_overrun=1. Pulse rx_ack -> rx_valid=0, rx_overrun=0.
- Low glitch of 4 clk on an idle line -> rx_busy pulses about 8 clk then clears; rx_valid and rx_frame_err stay 0.
- Frame 0x55 with stop bit driven 0 -> rx_frame_err 1-cycle pulse, rx_valid unchanged, rx_data keeps its previous value. Line held low: no new frame until the line goes high.
- Pull reset_n low at data bit 4 of a frame, release, then send 0x81 -> all outputs 0 during reset, then 0x81 is received correctly.
- With UART_RX_PARITY_EN defined: 0x07 with parity bit 1 -> accepted. 0x07 with parity bit 0 -> rx_parity_err pulse, rx_valid stays 0.
